wave_capture_trig: RTL and testbench



---
 rtl/wave_capture_pkg.sv | 21 ++
 rtl/dffr.sv | 18 +
 rtl/dffre.sv | 17 +
 rtl/wave_trigger_detect.sv | 56 +++++
 rtl/wave_capture_trig.sv | 104 ++++++++++
 tb/tb_wave_capture_trig.sv | 243 ++++++++++++++++++++++++
 6 files changed

// File: rtl/wave_capture_pkg.sv
// Shared definitions for the ping-pong waveform capture block: FSM encodings
// and the signed-to-offset-binary sample conversion.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    // Keeps the top out_w bits of a sample_w-bit two's-complement value and
    // flips the MSB, which equals adding 2**(out_w-1) modulo 2**out_w.
    function automatic logic [31:0] offset_binary(input logic [63:0] s,
                                                  input int sample_w,
                                                  input int out_w);
        logic [63:0] top;
        top = s >> (sample_w - out_w);
        return top[31:0] ^ (32'h1 << (out_w - 1));
    endfunction

endpackage

// File: rtl/dffr.sv
// Resettable D flop bank, synchronous active-high reset.
module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (r) q <= '0;
        else   q <= d;
    end

endmodule

// File: rtl/dffre.sv
// Resettable D flop bank with load enable, synchronous active-high reset.
module dffre #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (r)       q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/wave_trigger_detect.sv
// Level/slope trigger with auto-trigger timeout. Trigger settings are shadowed
// on arm so mid-capture input changes cannot disturb the current capture.
module wave_trigger_detect
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 strobe,
    input  logic [SAMPLE_W-1:0]  sample,
    input  logic [SAMPLE_W-1:0]  trig_level,
    input  logic                 trig_falling,
    input  logic                 auto_en,
    input  logic [TIMEOUT_W-1:0] auto_timeout,
    output logic                 trigger,
    output logic                 forced
);

    logic [SAMPLE_W-1:0]  level_q;
    logic                 falling_q;
    logic                 auto_en_q;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [TIMEOUT_W-1:0] tcnt_d;
    logic                 prev_above;
    logic                 prev_valid;
    logic                 prev_valid_d;
    logic                 above;
    logic                 edge_hit;
    logic                 timeout_hit;

    dffre #(.WIDTH(SAMPLE_W))  u_level   (.clk(clk), .r(reset), .en(arm), .d(trig_level),   .q(level_q));
    dffre #(.WIDTH(1))         u_falling (.clk(clk), .r(reset), .en(arm), .d(trig_falling), .q(falling_q));
    dffre #(.WIDTH(1))         u_auto_en (.clk(clk), .r(reset), .en(arm), .d(auto_en),      .q(auto_en_q));
    dffre #(.WIDTH(TIMEOUT_W)) u_timeout (.clk(clk), .r(reset), .en(arm), .d(auto_timeout), .q(timeout_q));

    assign above = $signed(sample) >= $signed(level_q);

    // The first strobe after arming only seeds prev_above; it can never be an edge.
    assign prev_valid_d = arm ? 1'b0 : (strobe ? 1'b1 : prev_valid);
    assign tcnt_d       = arm ? '0 : (strobe ? tcnt + TIMEOUT_W'(1) : tcnt);

    dffr  #(.WIDTH(1))         u_prev_valid (.clk(clk), .r(reset), .d(prev_valid_d), .q(prev_valid));
    dffre #(.WIDTH(1))         u_prev_above (.clk(clk), .r(reset), .en(strobe), .d(above), .q(prev_above));
    dffr  #(.WIDTH(TIMEOUT_W)) u_tcnt       (.clk(clk), .r(reset), .d(tcnt_d), .q(tcnt));

    assign edge_hit    = prev_valid & (falling_q ? (prev_above & ~above) : (~prev_above & above));
    assign timeout_hit = auto_en_q & (timeout_q != '0) & (tcnt == timeout_q - TIMEOUT_W'(1));

    assign trigger = strobe & (edge_hit | timeout_hit);
    assign forced  = strobe & timeout_hit & ~edge_hit;

endmodule

// File: rtl/wave_capture_trig.sv
// Ping-pong waveform capture: writes DEPTH post-trigger samples into the half
// of the display RAM not currently owned by the display.
module wave_capture_trig
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int OUT_W      = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic                  wave_display_idle,
    input  logic [SAMPLE_W-1:0]   trig_level,
    input  logic                  trig_falling,
    input  logic                  auto_en,
    input  logic [TIMEOUT_W-1:0]  auto_timeout,
    output logic [DEPTH_LOG2:0]   write_address,
    output logic                  write_enable,
    output logic [OUT_W-1:0]      write_sample,
    output logic                  read_index,
    output logic                  capture_done,
    output logic                  auto_triggered
);

    state_t                state;
    state_t                state_next;
    logic [1:0]            state_q;
    logic [DEPTH_LOG2-1:0] count;
    logic [DEPTH_LOG2-1:0] count_next;
    logic                  arm;
    logic                  strobe_armed;
    logic                  last_write;
    logic                  trigger;
    logic                  forced;

    assign state        = state_t'(state_q);
    assign arm          = (state == ST_WAIT) & wave_display_idle;
    assign strobe_armed = new_sample_ready & (state == ST_ARMED);
    assign last_write   = new_sample_ready & (state == ST_ACTIVE) & (&count);

    wave_trigger_detect #(
        .SAMPLE_W (SAMPLE_W),
        .TIMEOUT_W(TIMEOUT_W)
    ) u_detect (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .strobe      (strobe_armed),
        .sample      (new_sample_in),
        .trig_level  (trig_level),
        .trig_falling(trig_falling),
        .auto_en     (auto_en),
        .auto_timeout(auto_timeout),
        .trigger     (trigger),
        .forced      (forced)
    );

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned and infers a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            ST_WAIT: begin
                if (wave_display_idle) begin
                    state_next = ST_ARMED;
                    count_next = '0;
                end
            end
            ST_ARMED: begin
                if (trigger) begin
                    state_next = ST_ACTIVE;
                    count_next = DEPTH_LOG2'(1);
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    count_next = count + DEPTH_LOG2'(1);
                    if (&count) state_next = ST_WAIT;
                end
            end
            default: begin
                state_next = ST_WAIT;
                count_next = '0;
            end
        endcase
    end

    dffr  #(.WIDTH(2))          u_state  (.clk(clk), .r(reset), .d(state_next), .q(state_q));
    dffr  #(.WIDTH(DEPTH_LOG2)) u_count  (.clk(clk), .r(reset), .d(count_next), .q(count));
    dffr  #(.WIDTH(1))          u_ridx   (.clk(clk), .r(reset), .d(read_index ^ arm), .q(read_index));
    dffr  #(.WIDTH(1))          u_done   (.clk(clk), .r(reset), .d(last_write), .q(capture_done));
    dffre #(.WIDTH(1))          u_autotr (.clk(clk), .r(reset), .en(trigger), .d(forced), .q(auto_triggered));

    // Count is zero throughout ARMED, so the triggering sample lands at offset 0.
    assign write_enable  = new_sample_ready & ((state == ST_ACTIVE) | trigger);
    assign write_address = {~read_index, count};
    assign write_sample  = write_enable ? OUT_W'(offset_binary(64'(new_sample_in), SAMPLE_W, OUT_W))
                                        : '1;

endmodule

// File: tb/tb_wave_capture_trig.sv
// Directed self-checking bench for wave_capture_trig with hand-derived vectors.
module tb_wave_capture_trig;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = '0;
    logic        wave_display_idle = 1'b0;
    logic [15:0] trig_level = '0;
    logic        trig_falling = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] auto_timeout = '0;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;
    logic        capture_done;
    logic        auto_triggered;

    int checks = 0;
    int failures = 0;
    logic ri_model = 1'b0;

    wave_capture_trig dut (
        .clk(clk), .reset(reset),
        .new_sample_ready(new_sample_ready), .new_sample_in(new_sample_in),
        .wave_display_idle(wave_display_idle), .trig_level(trig_level),
        .trig_falling(trig_falling), .auto_en(auto_en), .auto_timeout(auto_timeout),
        .write_address(write_address), .write_enable(write_enable),
        .write_sample(write_sample), .read_index(read_index),
        .capture_done(capture_done), .auto_triggered(auto_triggered)
    );

    always #5 clk = ~clk;

    // One strobe: inputs set at negedge, outputs captured 1ns later.
    task automatic send(input logic [15:0] s, output logic we, output logic [8:0] a,
                        output logic [7:0] ws);
        @(negedge clk);
        new_sample_ready = 1'b1;
        new_sample_in    = s;
        #1;
        we = write_enable;
        a  = write_address;
        ws = write_sample;
        @(posedge clk);
        #1 new_sample_ready = 1'b0;
    endtask

    task automatic arm(input logic [15:0] lvl, input logic fall, input logic aen,
                       input logic [15:0] tmo);
        @(negedge clk);
        trig_level = lvl; trig_falling = fall; auto_en = aen; auto_timeout = tmo;
        wave_display_idle = 1'b1;
        @(posedge clk);
        #1 wave_display_idle = 1'b0;
        ri_model = ~ri_model;
        checks++;
        if (read_index !== ri_model) begin
            failures++;
            $display("FAIL arm_read_index: got %0b expected %0b", read_index, ri_model);
        end
    endtask

    // Writes 1..255 of a capture, then the done pulse, then no writes in WAIT.
    task automatic run_body(input string tag);
        logic we; logic [8:0] a; logic [7:0] ws;
        for (int k = 1; k < 256; k++) begin
            logic [15:0] s;
            logic [7:0]  kb;
            s  = 16'(k) << 8;
            kb = 8'(k);
            send(s, we, a, ws);
            checks++;
            if (we !== 1'b1 || a !== {~ri_model, kb} || ws !== (kb ^ 8'h80)) begin
                failures++;
                $display("FAIL %s_body[%0d]: got we=%0b addr=%h data=%h expected we=1 addr=%h data=%h",
                         tag, k, we, a, ws, {~ri_model, kb}, kb ^ 8'h80);
            end
        end
        checks++;
        if (capture_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_pulse: got %0b expected 1", tag, capture_done);
        end
        send(16'h0100, we, a, ws);
        checks++;
        if (capture_done !== 1'b0 || we !== 1'b0 || ws !== 8'hFF || read_index !== ri_model) begin
            failures++;
            $display("FAIL %s_after_done: got done=%0b we=%0b data=%h ridx=%0b expected 0 0 ff %0b",
                     tag, capture_done, we, ws, read_index, ri_model);
        end
    endtask

    task automatic expect_write(input string tag, input logic we, input logic [8:0] a,
                                input logic [7:0] ws, input logic ewe, input logic [7:0] ews);
        checks++;
        if (we !== ewe || (ewe && (a !== {~ri_model, 8'h00} || ws !== ews))) begin
            failures++;
            $display("FAIL %s: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                     tag, we, a, ws, ewe, {~ri_model, 8'h00}, ews);
        end
    endtask

    task automatic test_reset();
        logic we; logic [8:0] a; logic [7:0] ws;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ri_model = 1'b0;
        checks++;
        if (read_index !== 1'b0 || capture_done !== 1'b0 || auto_triggered !== 1'b0 ||
            write_enable !== 1'b0 || write_sample !== 8'hFF) begin
            failures++;
            $display("FAIL reset_state: got ridx=%0b done=%0b auto=%0b we=%0b data=%h expected 0 0 0 0 ff",
                     read_index, capture_done, auto_triggered, write_enable, write_sample);
        end
        send(16'h4000, we, a, ws);
        expect_write("wait_no_write", we, a, ws, 1'b0, 8'hFF);
    endtask

    task automatic test_rising();
        logic we; logic [8:0] a; logic [7:0] ws;
        arm(16'h0000, 1'b0, 1'b0, 16'd0);
        send(-16'sd5, we, a, ws);  expect_write("rise_m5", we, a, ws, 1'b0, 8'hFF);
        send(-16'sd1, we, a, ws);  expect_write("rise_m1", we, a, ws, 1'b0, 8'hFF);
        send(16'sd3, we, a, ws);   expect_write("rise_trig", we, a, ws, 1'b1, 8'h80);
        run_body("rise");
    endtask

    task automatic test_falling();
        logic we; logic [8:0] a; logic [7:0] ws;
        arm(16'h1000, 1'b1, 1'b0, 16'd0);
        send(16'h2000, we, a, ws); expect_write("fall_2000", we, a, ws, 1'b0, 8'hFF);
        send(16'h1000, we, a, ws); expect_write("fall_1000", we, a, ws, 1'b0, 8'hFF);
        send(16'h0FFF, we, a, ws); expect_write("fall_trig", we, a, ws, 1'b1, 8'h8F);
        run_body("fall");
    endtask

    task automatic test_first_sample();
        logic we; logic [8:0] a; logic [7:0] ws;
        arm(16'h0000, 1'b0, 1'b0, 16'd0);
        // Idle is ignored while ARMED: read_index must not toggle again.
        @(negedge clk) wave_display_idle = 1'b1;
        @(posedge clk) #1 wave_display_idle = 1'b0;
        checks++;
        if (read_index !== ri_model) begin
            failures++;
            $display("FAIL idle_in_armed: got ridx=%0b expected %0b", read_index, ri_model);
        end
        send(16'sd100, we, a, ws); expect_write("first_pos", we, a, ws, 1'b0, 8'hFF);
        send(-16'sd3, we, a, ws);  expect_write("first_neg", we, a, ws, 1'b0, 8'hFF);
        send(16'sd50, we, a, ws);  expect_write("first_trig", we, a, ws, 1'b1, 8'h80);
        run_body("first");
    endtask

    task automatic test_auto();
        logic we; logic [8:0] a; logic [7:0] ws;
        int writes;
        arm(16'h0000, 1'b0, 1'b1, 16'd4);
        auto_timeout = 16'd100;  // must not matter until the next arm
        for (int i = 1; i <= 3; i++) begin
            send(16'sd100, we, a, ws);
            expect_write("auto_pre", we, a, ws, 1'b0, 8'hFF);
        end
        send(16'sd100, we, a, ws); expect_write("auto_trig", we, a, ws, 1'b1, 8'h80);
        checks++;
        if (auto_triggered !== 1'b1) begin
            failures++;
            $display("FAIL auto_flag_set: got %0b expected 1", auto_triggered);
        end
        run_body("auto");

        // Real edge coincides with the forced trigger on the 3rd strobe.
        arm(16'h0000, 1'b0, 1'b1, 16'd3);
        send(-16'sd5, we, a, ws); expect_write("both_1", we, a, ws, 1'b0, 8'hFF);
        send(-16'sd5, we, a, ws); expect_write("both_2", we, a, ws, 1'b0, 8'hFF);
        send(16'sd5, we, a, ws);  expect_write("both_trig", we, a, ws, 1'b1, 8'h80);
        checks++;
        if (auto_triggered !== 1'b0) begin
            failures++;
            $display("FAIL edge_wins_flag: got %0b expected 0", auto_triggered);
        end
        run_body("both");

        arm(16'h0000, 1'b0, 1'b1, 16'd0);
        writes = 0;
        for (int i = 0; i < 1000; i++) begin
            send(16'sd100, we, a, ws);
            if (we === 1'b1) writes++;
        end
        checks++;
        if (writes != 0) begin
            failures++;
            $display("FAIL timeout_zero: got %0d writes expected 0", writes);
        end
    endtask

    task automatic test_reset_mid_capture();
        logic we; logic [8:0] a; logic [7:0] ws;
        reset = 1'b1;
        @(posedge clk) #1 reset = 1'b0;
        ri_model = 1'b0;
        arm(16'h0000, 1'b0, 1'b0, 16'd0);
        send(-16'sd1, we, a, ws);
        send(16'sd1, we, a, ws);   expect_write("mid_trig", we, a, ws, 1'b1, 8'h80);
        for (int k = 1; k < 100; k++) send(16'h0000, we, a, ws);
        @(negedge clk);
        new_sample_ready = 1'b1; new_sample_in = 16'h2000; reset = 1'b1;
        @(posedge clk) #1 reset = 1'b0;
        ri_model = 1'b0;
        checks++;
        if (read_index !== 1'b0 || write_enable !== 1'b0 || write_sample !== 8'hFF ||
            write_address !== 9'h100 || capture_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got ridx=%0b we=%0b data=%h addr=%h done=%0b expected 0 0 ff 100 0",
                     read_index, write_enable, write_sample, write_address, capture_done);
        end
        new_sample_ready = 1'b0;
        arm(16'h0000, 1'b0, 1'b0, 16'd0);
        send(-16'sd1, we, a, ws);
        send(16'sd1, we, a, ws);   expect_write("restart_trig", we, a, ws, 1'b1, 8'h80);
        run_body("restart");
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_first_sample();
        test_auto();
        test_reset_mid_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
